fc_layer_v2: RTL and testbench

FC_LAYER_V2 -- requirements
Module: fc_layer_v2

---
 rtl/fc_layer_v2_if.sv | 25 ++
 rtl/fc_layer_v2.sv | 189 ++++++++++++++++++
 tb/tb_fc_layer_v2.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_layer_v2_if.sv
// Memory-side bus of the fully connected layer engine:
// one read port with 1-cycle latency and one write port.
interface fc_layer_v2_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/fc_layer_v2.sv
// Fully connected layer: streams weights from memory, MACs
// against buffered inputs, adds bias, saturates, activates.
module fc_layer_v2 #(
  parameter int DW      = 16,
  parameter int FRAC    = 8,
  parameter int N_IN    = 10,
  parameter int N_OUT   = 5,
  parameter int AW      = 16,
  parameter int BIAS_EN = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [1:0]    act_mode,
  input  logic [AW-1:0] in_base,
  input  logic [AW-1:0] w_base,
  input  logic [AW-1:0] b_base,
  input  logic [AW-1:0] out_base,
  fc_layer_v2_if.master mem,
  output logic          busy,
  output logic          done
);
  localparam int CW  = $clog2(N_IN + 1);
  localparam int OW  = $clog2(N_OUT + 1);
  localparam int ACW = 2 * DW + CW;

  localparam logic signed [ACW-1:0] SMAX =
    {{(ACW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACW-1:0] SMIN =
    {{(ACW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] R6 =
    DW'(6 << FRAC);

  typedef enum logic [2:0] {
    IDLE, LOAD_IN, BIAS, MAC, DRAIN, WRITE, FIN
  } state_t;

  state_t state;

  logic [CW-1:0]  cnt;
  logic [OW-1:0]  oi;
  logic [1:0]     act;
  logic [AW-1:0]  wa, ba, oa;
  logic           rd_en, wr_en;
  logic [AW-1:0]  rd_addr, wr_addr;
  logic [DW-1:0]  wr_data;

  logic signed [DW-1:0]    x [N_IN];
  logic signed [ACW-1:0]   acc, sum, sh, bias_ext;
  logic signed [DW-1:0]    xs, sat, res;
  logic        [2*DW-1:0]  prod;

  assign mem.rd_en   = rd_en;
  assign mem.rd_addr = rd_addr;
  assign mem.wr_en   = wr_en;
  assign mem.wr_addr = wr_addr;
  assign mem.wr_data = wr_data;

  // Weight returning now pairs with the input issued one slot earlier.
  always_comb begin
    xs = '0;
    for (int i = 0; i < N_IN; i++) begin
      if ((state == DRAIN && i == N_IN - 1) ||
          (state == MAC && cnt == CW'(i + 1)))
        xs = x[i];
    end
    prod = {{DW{xs[DW-1]}}, xs} *
           {{DW{mem.rd_data[DW-1]}}, mem.rd_data};
    sum = acc + {{CW{prod[2*DW-1]}}, prod};
    sh  = sum >>> FRAC;
    if (sh > SMAX)
      sat = {1'b0, {(DW-1){1'b1}}};
    else if (sh < SMIN)
      sat = {1'b1, {(DW-1){1'b0}}};
    else
      sat = sh[DW-1:0];
    res = sat;
    case (act)
      2'b01: if (sat < 0) res = '0;
      2'b10: begin
        if (sat < 0)       res = '0;
        else if (sat > R6) res = R6;
      end
      default: res = sat;
    endcase
    if (BIAS_EN != 0)
      bias_ext = {{(ACW-DW){mem.rd_data[DW-1]}},
                  mem.rd_data};
    else
      bias_ext = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      oi      <= '0;
      act     <= '0;
      wa      <= '0;
      ba      <= '0;
      oa      <= '0;
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      rd_addr <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < N_IN; i++) x[i] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= LOAD_IN;
          busy    <= 1'b1;
          act     <= act_mode;
          wa      <= w_base;
          ba      <= b_base;
          oa      <= out_base;
          rd_en   <= 1'b1;
          rd_addr <= in_base;
          cnt     <= '0;
          oi      <= '0;
        end
        LOAD_IN: begin
          for (int i = 0; i < N_IN; i++)
            if (cnt == CW'(i + 1)) x[i] <= mem.rd_data;
          if (cnt == CW'(N_IN)) begin
            state   <= BIAS;
            rd_en   <= 1'b1;
            rd_addr <= ba;
            ba      <= ba + AW'(1);
            cnt     <= '0;
          end else begin
            cnt     <= cnt + CW'(1);
            rd_en   <= (cnt != CW'(N_IN - 1));
            rd_addr <= rd_addr + AW'(1);
          end
        end
        BIAS: begin
          state   <= MAC;
          rd_en   <= 1'b1;
          rd_addr <= wa;
          wa      <= wa + AW'(1);
          cnt     <= '0;
        end
        MAC: begin
          if (cnt == '0) acc <= bias_ext <<< FRAC;
          else           acc <= sum;
          if (cnt == CW'(N_IN - 1)) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_addr <= wa;
            wa      <= wa + AW'(1);
            cnt     <= cnt + CW'(1);
          end
        end
        DRAIN: begin
          state   <= WRITE;
          acc     <= sum;
          wr_en   <= 1'b1;
          wr_addr <= oa;
          oa      <= oa + AW'(1);
          wr_data <= res;
        end
        WRITE: begin
          wr_en <= 1'b0;
          if (oi == OW'(N_OUT - 1)) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            oi      <= oi + OW'(1);
            state   <= BIAS;
            rd_en   <= 1'b1;
            rd_addr <= ba;
            ba      <= ba + AW'(1);
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_layer_v2.sv
// Directed bench for fc_layer_v2 (N_IN=2, N_OUT=2) with a
// 1-cycle-latency memory model and a BIAS_EN=0 companion.
module tb_fc_layer_v2;
  localparam int DW = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, start, start2, clr;
  logic [1:0]    act_mode;
  logic [AW-1:0] in_base, w_base, b_base, out_base;
  logic          busy, done, busy2, done2;

  fc_layer_v2_if #(.AW(AW), .DW(DW)) bus ();
  fc_layer_v2_if #(.AW(AW), .DW(DW)) bus2 ();

  fc_layer_v2 #(.DW(DW), .FRAC(8), .N_IN(2), .N_OUT(2),
                .AW(AW), .BIAS_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .act_mode(act_mode), .in_base(in_base),
    .w_base(w_base), .b_base(b_base),
    .out_base(out_base), .mem(bus),
    .busy(busy), .done(done)
  );

  fc_layer_v2 #(.DW(DW), .FRAC(8), .N_IN(2), .N_OUT(2),
                .AW(AW), .BIAS_EN(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2),
    .act_mode(act_mode), .in_base(in_base),
    .w_base(w_base), .b_base(b_base),
    .out_base(out_base), .mem(bus2),
    .busy(busy2), .done(done2)
  );

  logic [15:0] mem   [256];
  logic [15:0] outm  [256];
  logic [15:0] outm2 [256];
  int wr_cnt = 0;
  int wr_cnt2 = 0;
  int ovl = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[7:0]];
    if (bus.rd_en && bus.wr_en) ovl <= ovl + 1;
    if (clr) begin
      wr_cnt <= 0;
      for (int i = 0; i < 256; i++) outm[i] <= 16'hDEAD;
    end else if (bus.wr_en) begin
      outm[bus.wr_addr[7:0]] <= bus.wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (bus2.rd_en) bus2.rd_data <= mem[bus2.rd_addr[7:0]];
    if (clr) begin
      wr_cnt2 <= 0;
      for (int i = 0; i < 256; i++) outm2[i] <= 16'hDEAD;
    end else if (bus2.wr_en) begin
      outm2[bus2.wr_addr[7:0]] <= bus2.wr_data;
      wr_cnt2 <= wr_cnt2 + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_case(
    input logic [15:0] x0, x1, w00, w01,
    input logic [15:0] w10, w11, b0, b1
  );
    mem[8'h10] = x0;  mem[8'h11] = x1;
    mem[8'h20] = w00; mem[8'h21] = w01;
    mem[8'h22] = w10; mem[8'h23] = w11;
    mem[8'h30] = b0;  mem[8'h31] = b1;
  endtask

  task automatic clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic launch(input bit sel, input logic [1:0] am);
    act_mode = am;
    if (sel) start2 = 1'b1;
    else     start  = 1'b1;
    tick();
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic observe(
    input bit sel, input int poke,
    output int lat, output int nd, output bit bok
  );
    logic b, d;
    lat = -1;
    nd  = 0;
    bok = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      b = sel ? busy2 : busy;
      d = sel ? done2 : done;
      if (c == poke) begin
        start    = 1'b1;
        act_mode = 2'b01;
        out_base = 16'h0050;
      end
      if (c == poke + 1) start = 1'b0;
      if ((c <= 14) != (b === 1'b1)) bok = 1'b0;
      if (d === 1'b1) begin
        nd++;
        if (lat < 0) lat = c;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_done got=%b%b exp=00",
               busy, done);
    end
    checks++;
    if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_en got=%b%b exp=00",
               bus.rd_en, bus.wr_en);
    end
    checks++;
    if ({bus.rd_addr, bus.wr_addr, bus.wr_data} !== 48'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h %h %h exp=0",
               bus.rd_addr, bus.wr_addr, bus.wr_data);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, nd;
    bit bok;
    set_case(16'd256, 16'd512, 16'd256, 16'd256,
             16'hFE00, 16'd0, 16'd256, 16'd0);
    clear();
    launch(1'b0, 2'b00);
    observe(1'b0, -5, lat, nd, bok);
    checks++;
    if (lat !== 14) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=14", lat);
    end
    checks++;
    if (nd !== 1) begin
      failures++;
      $display("FAIL basic_done_count got=%0d exp=1", nd);
    end
    checks++;
    if (bok !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy_window got=%b exp=1", bok);
    end
    checks++;
    if (wr_cnt !== 2) begin
      failures++;
      $display("FAIL basic_wr_count got=%0d exp=2", wr_cnt);
    end
    checks++;
    if (outm[8'h40] !== 16'd1024) begin
      failures++;
      $display("FAIL basic_out0 got=%h exp=0400", outm[8'h40]);
    end
    checks++;
    if (outm[8'h41] !== 16'hFE00) begin
      failures++;
      $display("FAIL basic_out1 got=%h exp=fe00", outm[8'h41]);
    end
  endtask

  task automatic test_relu();
    int lat, nd;
    bit bok;
    clear();
    launch(1'b0, 2'b01);
    observe(1'b0, -5, lat, nd, bok);
    checks++;
    if (outm[8'h40] !== 16'd1024) begin
      failures++;
      $display("FAIL relu_out0 got=%h exp=0400", outm[8'h40]);
    end
    checks++;
    if (outm[8'h41] !== 16'h0000) begin
      failures++;
      $display("FAIL relu_out1 got=%h exp=0000", outm[8'h41]);
    end
  endtask

  task automatic test_relu6();
    int lat, nd;
    bit bok;
    set_case(16'd256, 16'd512, 16'd1024, 16'd1024,
             16'hFE00, 16'd0, 16'd0, 16'd0);
    clear();
    launch(1'b0, 2'b10);
    observe(1'b0, -5, lat, nd, bok);
    checks++;
    if (outm[8'h40] !== 16'd1536) begin
      failures++;
      $display("FAIL relu6_out0 got=%h exp=0600", outm[8'h40]);
    end
    checks++;
    if (outm[8'h41] !== 16'h0000) begin
      failures++;
      $display("FAIL relu6_out1 got=%h exp=0000", outm[8'h41]);
    end
  endtask

  task automatic test_saturate();
    int lat, nd;
    bit bok;
    set_case(16'h7F00, 16'd0, 16'h7F00, 16'd0,
             16'hFE00, 16'd0, 16'd0, 16'd0);
    clear();
    launch(1'b0, 2'b00);
    observe(1'b0, -5, lat, nd, bok);
    checks++;
    if (outm[8'h40] !== 16'h7FFF) begin
      failures++;
      $display("FAIL sat_pos got=%h exp=7fff", outm[8'h40]);
    end
    checks++;
    if (outm[8'h41] !== 16'h8000) begin
      failures++;
      $display("FAIL sat_neg_out1 got=%h exp=8000", outm[8'h41]);
    end
    mem[8'h20] = 16'h8100;
    clear();
    launch(1'b0, 2'b00);
    observe(1'b0, -5, lat, nd, bok);
    checks++;
    if (outm[8'h40] !== 16'h8000) begin
      failures++;
      $display("FAIL sat_neg got=%h exp=8000", outm[8'h40]);
    end
  endtask

  task automatic test_start_ignored();
    int lat, nd;
    bit bok;
    set_case(16'd256, 16'd512, 16'd256, 16'd256,
             16'hFE00, 16'd0, 16'd256, 16'd0);
    clear();
    launch(1'b0, 2'b00);
    observe(1'b0, 6, lat, nd, bok);
    out_base = 16'h0040;
    checks++;
    if (nd !== 1 || lat !== 14) begin
      failures++;
      $display("FAIL restart_done got=%0d@%0d exp=1@14",
               nd, lat);
    end
    checks++;
    if (outm[8'h41] !== 16'hFE00 || outm[8'h50] !== 16'hDEAD) begin
      failures++;
      $display("FAIL restart_out got=%h %h exp=fe00 dead",
               outm[8'h41], outm[8'h50]);
    end
    checks++;
    if (wr_cnt !== 2) begin
      failures++;
      $display("FAIL restart_wr_count got=%0d exp=2", wr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nd;
    bit bok;
    clear();
    launch(1'b0, 2'b00);
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if ({busy, done, bus.rd_en, bus.wr_en} !== 4'b0) begin
      failures++;
      $display("FAIL midrst_ctrl got=%b%b%b%b exp=0000",
               busy, done, bus.rd_en, bus.wr_en);
    end
    checks++;
    if ({bus.rd_addr, bus.wr_addr, bus.wr_data} !== 48'h0) begin
      failures++;
      $display("FAIL midrst_bus got=%h %h %h exp=0",
               bus.rd_addr, bus.wr_addr, bus.wr_data);
    end
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    checks++;
    if (wr_cnt !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_quiet got=%0d busy=%b exp=0 0",
               wr_cnt, busy);
    end
    clear();
    launch(1'b0, 2'b00);
    observe(1'b0, -5, lat, nd, bok);
    checks++;
    if (lat !== 14 || outm[8'h40] !== 16'd1024 ||
        outm[8'h41] !== 16'hFE00) begin
      failures++;
      $display("FAIL midrst_rerun got=%0d %h %h exp=14 0400 fe00",
               lat, outm[8'h40], outm[8'h41]);
    end
  endtask

  task automatic test_bias_off();
    int lat, nd;
    bit bok;
    clear();
    launch(1'b1, 2'b00);
    observe(1'b1, -5, lat, nd, bok);
    checks++;
    if (outm2[8'h40] !== 16'd768) begin
      failures++;
      $display("FAIL nobias_out0 got=%h exp=0300", outm2[8'h40]);
    end
    checks++;
    if (lat !== 14 || bok !== 1'b1 || wr_cnt2 !== 2) begin
      failures++;
      $display("FAIL nobias_timing got=%0d %b %0d exp=14 1 2",
               lat, bok, wr_cnt2);
    end
  endtask

  task automatic test_wrap();
    int lat, nd;
    bit bok;
    in_base  = 16'hFFFF;
    out_base = 16'hFFFF;
    mem[8'hFF] = 16'd256;
    mem[8'h00] = 16'd512;
    clear();
    launch(1'b0, 2'b00);
    observe(1'b0, -5, lat, nd, bok);
    in_base  = 16'h0010;
    out_base = 16'h0040;
    checks++;
    if (outm[8'hFF] !== 16'd1024) begin
      failures++;
      $display("FAIL wrap_out0 got=%h exp=0400", outm[8'hFF]);
    end
    checks++;
    if (outm[8'h00] !== 16'hFE00) begin
      failures++;
      $display("FAIL wrap_out1 got=%h exp=fe00", outm[8'h00]);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    start2   = 1'b0;
    clr      = 1'b0;
    act_mode = 2'b00;
    in_base  = 16'h0010;
    w_base   = 16'h0020;
    b_base   = 16'h0030;
    out_base = 16'h0040;
    test_reset();
    test_basic();
    test_relu();
    test_relu6();
    test_saturate();
    test_start_ignored();
    test_reset_mid();
    test_bias_off();
    test_wrap();
    checks++;
    if (ovl !== 0) begin
      failures++;
      $display("FAIL rd_wr_overlap got=%0d exp=0", ovl);
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
